// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus with a single
// outstanding transaction. The data port has priority, limited by a streak count.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int ALEN         = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ALEN-1:0] i_addr,
    output logic            i_done,
    output logic [31:0]     i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_owner_d;
    logic [SW-1:0]     r_streak;
    logic [CW-1:0]     r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ALEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_err;
    logic [31:0]       r_i_rdata;
    logic [XLEN-1:0]   r_d_rdata;

    logic              w_grant_d;
    logic              w_complete;
    logic              w_expire;
    logic [SW-1:0]     w_streak_inc;

    // A pending fetch only loses to the data port while the streak is below its limit.
    assign w_grant_d    = d_req && (!i_req || (r_streak < SW'(D_STREAK_MAX)));
    assign w_complete   = (r_state == ST_WAIT) && mem_rvalid;
    assign w_expire     = (r_cnt == CW'(TIMEOUT - 1));
    assign w_streak_inc = (r_streak == SW'(D_STREAK_MAX)) ? r_streak : r_streak + SW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_owner_d   <= 1'b0;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_be    <= d_be;
                        r_streak    <= i_req ? w_streak_inc : '0;
                        r_cnt       <= '0;
                        r_mem_req   <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else if (i_req) begin
                        r_owner_d   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                        r_streak    <= '0;
                        r_cnt       <= '0;
                        r_mem_req   <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A response on the expiry cycle still counts as a normal completion.
                    if (w_complete) begin
                        r_state  <= ST_DONE;
                        r_err    <= 1'b0;
                        r_i_done <= !r_owner_d;
                        r_d_done <= r_owner_d;
                        if (!r_owner_d) begin
                            r_i_rdata <= mem_rdata[31:0];
                        end else if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end else if (w_expire) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_i_done  <= !r_owner_d;
                        r_d_done  <= r_owner_d;
                        if (r_owner_d) begin
                            r_d_rdata <= '0;
                        end else begin
                            r_i_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if ((r_state == ST_ISSUE) && mem_ready) begin
                            r_state   <= ST_WAIT;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, 32, data width (from riscv_pkg).
REQ-002 Parameter ALEN, 32, address width (from riscv_pkg).
REQ-003 Parameter D_STREAK_MAX, 4, max consecutive D-port grants while i_req is pending.
REQ-004 Parameter TIMEOUT, 64, cycles from ISSUE entry before error completion.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-007 i_req  input  1  instruction fetch request, held until i_done.
REQ-008 i_addr  input  ALEN  fetch address, stable while i_req=1.
REQ-009 i_done  output  1  one-cycle fetch completion pulse.
REQ-010 i_rdata  output  32  fetched instruction, valid with i_done, held until next i_done.
REQ-011 d_req  input  1  data request, held until d_done.
REQ-012 d_we  input  1  1=store, 0=load.
REQ-013 d_addr  input  ALEN  data address.
REQ-014 d_wdata  input  XLEN  store data.
REQ-015 d_be  input  4  store byte enables.
REQ-016 d_done  output  1  one-cycle data completion pulse.
REQ-017 d_rdata  output  XLEN  load data, valid with d_done, held until next d_done.
REQ-018 err  output  1  timeout indication, meaningful only with i_done or d_done.
REQ-019 mem_req  output  1  shared memory request.
REQ-020 mem_we, mem_addr, mem_wdata, mem_be  output  1/ALEN/XLEN/4  latched fields of granted request.
REQ-021 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-022 mem_rvalid  input  1  response/ack of accepted transaction, at least 1 cycle after acceptance.
REQ-023 mem_rdata  input  XLEN  read data, valid with mem_rvalid.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT, DONE; one outstanding transaction at a time.
REQ-025 IDLE: grant D if d_req and (!i_req or streak<D_STREAK_MAX); else grant I if i_req; else stay IDLE.
REQ-026 On grant, owner, we (0 for I), addr, wdata, be (0 for I) are registered; next state ISSUE.
REQ-027 Streak: +1 on D grant with i_req=1; cleared on I grant or on a D grant with i_req=0; saturates at D_STREAK_MAX.
REQ-028 mem_req=1 only in ISSUE; mem_* fields driven from registers, stable throughout ISSUE/WAIT.
REQ-029 ISSUE with mem_ready=1 -> WAIT; otherwise remain in ISSUE.
REQ-030 WAIT with mem_rvalid=1 -> DONE; mem_rdata captured into owner's rdata (loads and fetches only); mem_rvalid outside WAIT ignored.
REQ-031 Timeout counter cleared on ISSUE entry, increments each ISSUE/WAIT cycle; reaching TIMEOUT-1 without completion -> DONE with err=1, owner rdata=0, mem_req dropped.
REQ-032 DONE: owner's done=1 for exactly one cycle, err registered; requests ignored; -> IDLE.
REQ-033 Minimum latency: grant to done = 4 cycles (IDLE, ISSUE, WAIT, DONE) with mem_ready immediate and mem_rvalid 1 cycle later.
REQ-034 Requester dropping req mid-transaction does not abort it; done still pulses.
REQ-035 Non-owner done is never asserted; i_done and d_done never high together.

Reset
REQ-036 rst=0 immediately forces state IDLE, streak=0, counter=0, all outputs 0 including i_rdata/d_rdata, regardless of clk.
REQ-037 Reset during ISSUE/WAIT abandons the transaction; no done pulse after release; first grant occurs no earlier than the first clk edge with rst=1.

Verification
REQ-038 I fetch 0x100, mem_ready=1 in first ISSUE cycle, mem_rvalid next cycle with 0x00500093 -> mem_req high 1 cycle, i_done 1 cycle, i_rdata=0x00500093, err=0.
REQ-039 i_req (0x104) and d_req (we=1, 0x2000, 0xDEADBEEF, be=0xF) raised same cycle -> store issued first with exact fields, d_done, then fetch issued.
REQ-040 d_req re-raised after every d_done, i_req held -> exactly 4 D grants, then I granted; streak cleared.
REQ-041 mem_ready held 0 for 3 cycles -> mem_req and fields stable, then accepted; completion on mem_rvalid.
REQ-042 Load accepted, mem_rvalid never asserted -> d_done with err=1, d_rdata=0 exactly 64 cycles after ISSUE entry; later mem_rvalid ignored.
REQ-043 rst=0 asserted mid-WAIT -> all outputs 0 without clk edge; after release, no spurious done, next request serviced normally.
